instr_fetch: RTL and testbench

Instruction fetch unit: the producer side of the instruction word that the instruction decoder consumes. It owns the program counter. It fetches 32-bit words from instruction memory over a req/ack bus and presents each word with its PC on a valid/ready handshake. On a redirect (jump, branch, trap) it discards any in-flight fetch and restarts from the new PC.

---
 rtl/instr_fetch.sv | 174 +++++++++++++++++
 tb/tb_instr_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack bus, hands them to decode.
// Optional misaligned-PC trap: define IFETCH_MISALIGN_TRAP_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DRAIN
`ifdef IFETCH_MISALIGN_TRAP_EN
    , S_FAULT
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        req_n, vld_n;
  logic [31:0] addr_n, instr_n, ipc_n;
  logic [31:0] rpc;
  logic        issue;
  logic [31:0] issue_addr;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_n;
  assign fault = fault_q;
  assign rpc   = redirect_pc;
`else
  assign fault = 1'b0;
  assign rpc   = redirect_pc & 32'hFFFF_FFFC;
`endif

  // Each arm only decides whether a new request is wanted and at what address;
  // the shared tail below turns that into FETCH (or FAULT when trapping).
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_n      = mem_req;
    addr_n     = mem_addr;
    vld_n      = instr_valid;
    instr_n    = instr;
    ipc_n      = instr_pc;
    issue      = 1'b0;
    issue_addr = pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
    fault_n    = fault_q;
`endif
    case (state)
      S_IDLE: begin
        issue      = 1'b1;
        issue_addr = pc;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_n = rpc;
          if (mem_ack) begin
            issue      = 1'b1;
            issue_addr = rpc;
          end else begin
            state_n = S_DRAIN;
          end
        end else if (mem_ack) begin
          instr_n = mem_rdata;
          ipc_n   = pc;
          vld_n   = 1'b1;
          pc_n    = pc + 32'd4;
          req_n   = 1'b0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          vld_n      = 1'b0;
          pc_n       = rpc;
          issue      = 1'b1;
          issue_addr = rpc;
        end else if (instr_ready) begin
          vld_n      = 1'b0;
          issue      = 1'b1;
          issue_addr = pc;
        end
      end
      S_DRAIN: begin
        // Stale data is dropped; the most recent redirect target is what gets fetched.
        if (redirect) begin
          pc_n = rpc;
          if (mem_ack) begin
            issue      = 1'b1;
            issue_addr = rpc;
          end
        end else if (mem_ack) begin
          issue      = 1'b1;
          issue_addr = pc;
        end
      end
`ifdef IFETCH_MISALIGN_TRAP_EN
      S_FAULT: begin
        if (redirect) begin
          pc_n       = rpc;
          issue      = 1'b1;
          issue_addr = rpc;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    if (issue) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
      if (issue_addr[1:0] != 2'b00) begin
        state_n = S_FAULT;
        req_n   = 1'b0;
        vld_n   = 1'b0;
        fault_n = 1'b1;
        ipc_n   = issue_addr;
      end else begin
        state_n = S_FETCH;
        req_n   = 1'b1;
        addr_n  = issue_addr;
        fault_n = 1'b0;
      end
`else
      state_n = S_FETCH;
      req_n   = 1'b1;
      addr_n  = issue_addr;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= 32'h0000_0000;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      mem_req     <= req_n;
      mem_addr    <= addr_n;
      instr_valid <= vld_n;
      instr       <= instr_n;
      instr_pc    <= ipc_n;
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_n;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed sequences, a stream-level PC/data model, bus-protocol checks.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr, mem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;
  int wait_cycles = 0;
  int hs_count = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  function automatic logic [31:0] redir_target(input logic [31:0] a);
`ifdef IFETCH_MISALIGN_TRAP_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: acks after wait_cycles idle request cycles; 0 means same-cycle ack.
  initial begin : responder
    bit busy;
    int cnt;
    busy = 0; cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (!rst_n) busy = 0;
      else if (mem_req) begin
        if (!busy) begin
          busy = 1;
          cnt  = wait_cycles;
        end
        if (cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = memfun(mem_addr);
          busy      = 0;
        end else cnt--;
      end
    end
  end

  // Stream model: want_pc is the PC the next delivered word must carry.
  initial begin : compare
    logic [31:0] want_pc, p_addr;
    logic p_req, p_ack, p_vld;
    want_pc = RST_PC; p_addr = '0; p_req = 0; p_ack = 0; p_vld = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        want_pc = RST_PC; p_req = 0; p_ack = 0; p_vld = 0;
      end else begin
        if (instr_valid) begin
          check("m_stream_pc", instr_pc, want_pc);
          check("m_stream_data", instr, memfun(instr_pc));
          check("m_no_req_in_hold", {31'b0, mem_req}, 32'd0);
          if (!p_vld) check("m_valid_after_ack", {31'b0, p_ack}, 32'd1);
        end
        if (mem_req && (!p_req || p_ack)) check("m_start_addr", mem_addr, want_pc);
        if (mem_req && p_req && !p_ack) check("m_addr_stable", mem_addr, p_addr);
        if (redirect) want_pc = redir_target(redirect_pc);
        else if (instr_valid && instr_ready) begin
          want_pc = instr_pc + 32'd4;
          hs_count++;
        end
        p_req = mem_req; p_ack = mem_ack; p_addr = mem_addr; p_vld = instr_valid;
      end
    end
  end

  initial begin : main
    int hs0;
    rst_n = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (3) tick();
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0000_0100);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_ipc", instr_pc, 32'h0000_0000);
    check("rst_fault", {31'b0, fault}, 32'd0);

    // First fetch with zero-wait memory
    rst_n = 1'b1;
    tick();
    check("f1_req", {31'b0, mem_req}, 32'd1);
    check("f1_addr", mem_addr, 32'h0000_0100);
    tick();
    check("f1_valid", {31'b0, instr_valid}, 32'd1);
    check("f1_instr", instr, 32'h0050_0093);
    check("f1_ipc", instr_pc, 32'h0000_0100);

    // Decoder stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_instr", instr, 32'h0050_0093);
      check("stall_ipc", instr_pc, 32'h0000_0100);
      check("stall_req", {31'b0, mem_req}, 32'd0);
    end

    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("f2_addr", mem_addr, 32'h0000_0104);
    check("f2_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    check("f2_instr", instr, 32'hC0DE_0104);

    // Back-to-back: one instruction every 2 cycles
    hs0 = hs_count;
    instr_ready = 1'b1;
    repeat (8) tick();
    instr_ready = 1'b0;
    check("b2b_count", hs_count - hs0, 32'd4);
    check("b2b_ipc", instr_pc, 32'h0000_0114);

    // Slow memory, redirect during the second wait cycle
    wait_cycles = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    check("dly_addr_a", mem_addr, 32'h0000_0100);
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    check("dly_addr_c", mem_addr, 32'h0000_0100);
    check("dly_valid_c", {31'b0, instr_valid}, 32'd0);
    tick();
    wait_cycles = 0;
    check("dly_ack_d", {31'b0, mem_ack}, 32'd1);
    check("dly_addr_d", mem_addr, 32'h0000_0100);
    tick();
    check("dly_new_addr", mem_addr, 32'h0000_0200);
    check("dly_new_req", {31'b0, mem_req}, 32'd1);
    check("dly_valid_e", {31'b0, instr_valid}, 32'd0);
    tick();
    check("dly_ipc", instr_pc, 32'h0000_0200);

    // Redirect beats instr_ready in HOLD
    redirect = 1'b1; redirect_pc = 32'h0000_0300; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("rr_addr", mem_addr, 32'h0000_0300);
    // Redirect coincident with ack: word dropped, refetch
    tick();
    redirect = 1'b0;
    check("ra_req", {31'b0, mem_req}, 32'd1);
    check("ra_valid", {31'b0, instr_valid}, 32'd0);
    check("ra_addr", mem_addr, 32'h0000_0300);
    tick();
    check("ra_instr", instr, 32'hC0DE_0300);

    // Several redirects while draining: last one wins
    wait_cycles = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0400;
    tick();
    redirect_pc = 32'h0000_0500;
    tick();
    redirect_pc = 32'h0000_0600;
    tick();
    redirect = 1'b0;
    tick();
    wait_cycles = 0;
    tick();
    check("drain_addr", mem_addr, 32'h0000_0600);
    tick();
    check("drain_ipc", instr_pc, 32'h0000_0600);

    // PC wraps at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("wrap_addr1", mem_addr, 32'h0000_0000);
    tick();
    check("wrap_instr", instr, 32'hC0DE_0000);

    // Misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0202;
    tick();
    redirect = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      check("mis_fault", {31'b0, fault}, 32'd1);
      check("mis_ipc", instr_pc, 32'h0000_0202);
      check("mis_req", {31'b0, mem_req}, 32'd0);
      tick();
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    check("mis_clear", {31'b0, fault}, 32'd0);
    check("mis_addr", mem_addr, 32'h0000_0300);
    tick();
`else
    check("mis_addr", mem_addr, 32'h0000_0200);
    check("mis_fault", {31'b0, fault}, 32'd0);
    tick();
    check("mis_ipc", instr_pc, 32'h0000_0200);
`endif

    // Async reset in the middle of a transaction
    wait_cycles = 5;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_req}, 32'd0);
    check("arst_valid", {31'b0, instr_valid}, 32'd0);
    check("arst_addr", mem_addr, 32'h0000_0100);
    tick();
    tick();
    wait_cycles = 0;
    rst_n = 1'b1;
    tick();
    check("rst2_addr", mem_addr, 32'h0000_0100);
    check("rst2_req", {31'b0, mem_req}, 32'd1);
    tick();
    check("rst2_instr", instr, 32'h0050_0093);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
